// File: rtl/test_sel_pkg.sv
// Shared types and helpers for the test-output stream selector.
// Holds the FSM encoding and the enable decode function.
package test_sel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        PASS  = 2'd2
    } sel_state_e;

    localparam int MAX_CH = 32;

    typedef struct packed {
        logic       ok;
        logic       multi;
        logic [4:0] idx;
    } dec_t;

    // ok: exactly one bit set (idx is its position); multi: more than one set
    function automatic dec_t onehot_decode(input logic [MAX_CH-1:0] v);
        dec_t        r;
        int unsigned n;
        r = '0;
        n = 0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (v[i]) begin
                n++;
                r.idx = 5'(i);
            end
        end
        r.ok    = (n == 1);
        r.multi = (n > 1);
        return r;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Width-parametrised two-flop synchroniser.
// Asynchronous active-high reset clears both stages.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/output_stream_selector.sv
// Registered test-output selector: synchronised one-hot enable,
// blanking on every source change, output strobe and sample counter.
module output_stream_selector
    import test_sel_pkg::*;
#(
    parameter int BW        = 21,
    parameter int NCH       = 4,
    parameter int BLANK_CYC = 4,
    parameter int CNTW      = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NCH*BW-1:0]       IN_DATA,
    input  logic [NCH-1:0]          IN_VALID,
    input  logic [NCH-1:0]          ENABLE,
    output logic [BW-1:0]           OUT,
    output logic                    OUT_VALID,
    output logic                    OUT_CLK,
    output logic [$clog2(NCH)-1:0]  ACTIVE_CH,
    output logic                    PASSING,
    output logic                    ERR_MULTI,
    output logic [CNTW-1:0]         SAMPLE_CNT
);

    localparam int CHW = $clog2(NCH);
    localparam int BCW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [BCW-1:0] BLANK_LD = BCW'(BLANK_CYC - 1);

    logic [NCH-1:0] ens;

    sync_2ff #(.W(NCH)) u_en_sync (
        .clk (CLK),
        .rst (RST),
        .d   (ENABLE),
        .q   (ens)
    );

    dec_t           dec;
    logic           tgt_ok;
    logic [CHW-1:0] tgt;

    assign dec    = onehot_decode(32'(ens));
    assign tgt_ok = dec.ok && ({27'd0, dec.idx} < 32'(NCH));
    assign tgt    = CHW'(dec.idx);

    sel_state_e      state_q, state_d;
    logic [CHW-1:0]  active_q, active_d;
    logic [BCW-1:0]  bcnt_q, bcnt_d;
    logic [BW-1:0]   out_q, out_d;
    logic            vld_q, vld_d;
    logic            oclk_q;
    logic            err_q;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic [BW-1:0]   sel_data;
    logic            sel_vld;
    logic            take;

    always_comb begin
        sel_data = '0;
        sel_vld  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (active_q == CHW'(i)) begin
                sel_data = IN_DATA[i*BW +: BW];
                sel_vld  = IN_VALID[i];
            end
        end
    end

    // A target change always wins over a same-cycle sample.
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        bcnt_d   = bcnt_q;
        out_d    = out_q;
        vld_d    = 1'b0;
        cnt_d    = cnt_q;
        take     = 1'b0;
        unique case (state_q)
            IDLE: begin
                out_d = '0;
                if (tgt_ok) begin
                    active_d = tgt;
                    bcnt_d   = BLANK_LD;
                    state_d  = BLANK;
                end
            end
            BLANK: begin
                out_d = '0;
                if (bcnt_q != '0) begin
                    bcnt_d = bcnt_q - BCW'(1);
                end else if (!tgt_ok) begin
                    state_d = IDLE;
                end else if (tgt != active_q) begin
                    active_d = tgt;
                    bcnt_d   = BLANK_LD;
                end else begin
                    state_d = PASS;
                    cnt_d   = '0;
                    take    = sel_vld;
                end
            end
            PASS: begin
                if (!tgt_ok) begin
                    state_d = IDLE;
                    out_d   = '0;
                end else if (tgt != active_q) begin
                    state_d  = BLANK;
                    active_d = tgt;
                    bcnt_d   = BLANK_LD;
                    out_d    = '0;
                end else begin
                    take = sel_vld;
                end
            end
            default: state_d = IDLE;
        endcase
        if (take) begin
            out_d = sel_data;
            vld_d = 1'b1;
            if (cnt_d != '1) cnt_d = cnt_d + CNTW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            active_q <= '0;
            bcnt_q   <= '0;
            out_q    <= '0;
            vld_q    <= 1'b0;
            oclk_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            bcnt_q   <= bcnt_d;
            out_q    <= out_d;
            vld_q    <= vld_d;
            oclk_q   <= vld_q;
            err_q    <= dec.multi;
            cnt_q    <= cnt_d;
        end
    end

    assign OUT        = out_q;
    assign OUT_VALID  = vld_q;
    assign OUT_CLK    = oclk_q;
    assign ACTIVE_CH  = active_q;
    assign PASSING    = (state_q == PASS);
    assign ERR_MULTI  = err_q;
    assign SAMPLE_CNT = cnt_q;

endmodule

// File: tb/tb_output_stream_selector.sv
// Randomised bench for output_stream_selector against a
// cycle-level behavioural model of the selection rules.
module tb_output_stream_selector;

    localparam int BW        = 21;
    localparam int NCH       = 4;
    localparam int BLANK_CYC = 4;
    localparam int CNTW      = 4;
    localparam int CHW       = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH*BW-1:0] in_data = '0;
    logic [NCH-1:0]    in_valid = '0;
    logic [NCH-1:0]    enable = '0;
    logic [BW-1:0]     out;
    logic              out_valid;
    logic              out_clk;
    logic [CHW-1:0]    active_ch;
    logic              passing;
    logic              err_multi;
    logic [CNTW-1:0]   sample_cnt;

    output_stream_selector #(
        .BW(BW), .NCH(NCH), .BLANK_CYC(BLANK_CYC), .CNTW(CNTW)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .IN_DATA    (in_data),
        .IN_VALID   (in_valid),
        .ENABLE     (enable),
        .OUT        (out),
        .OUT_VALID  (out_valid),
        .OUT_CLK    (out_clk),
        .ACTIVE_CH  (active_ch),
        .PASSING    (passing),
        .ERR_MULTI  (err_multi),
        .SAMPLE_CNT (sample_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // model: enable history, mode 0=idle 1=blank 2=pass
    logic [NCH-1:0] en_hist [2];
    int             m_mode, m_left, m_act, m_cnt;
    logic [BW-1:0]  m_out;
    bit             m_vld, m_clk, m_err;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        en_hist[0] = '0;
        en_hist[1] = '0;
        m_mode = 0; m_left = 0; m_act = 0; m_cnt = 0;
        m_out = '0; m_vld = 0; m_clk = 0; m_err = 0;
    endtask

    task automatic model_fwd();
        if (in_valid[m_act]) begin
            m_out = in_data[m_act*BW +: BW];
            m_vld = 1;
            m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
        end
    endtask

    task automatic model_step();
        logic [NCH-1:0] e;
        int n, t;
        e = en_hist[1];
        en_hist[1] = en_hist[0];
        en_hist[0] = enable;
        n = $countones(e);
        t = -1;
        for (int i = 0; i < NCH; i++) if (e[i]) t = i;
        m_clk = m_vld;
        m_vld = 0;
        m_err = (n > 1);
        case (m_mode)
            0: begin
                m_out = '0;
                if (n == 1) begin m_mode = 1; m_left = BLANK_CYC; m_act = t; end
            end
            1: begin
                m_out = '0;
                m_left--;
                if (m_left == 0) begin
                    if (n != 1) m_mode = 0;
                    else if (t != m_act) begin m_act = t; m_left = BLANK_CYC; end
                    else begin m_mode = 2; m_cnt = 0; model_fwd(); end
                end
            end
            default: begin
                if (n != 1) begin m_mode = 0; m_out = '0; end
                else if (t != m_act) begin
                    m_mode = 1; m_left = BLANK_CYC; m_act = t; m_out = '0;
                end else model_fwd();
            end
        endcase
    endtask

    task automatic check_all();
        check("out", 32'(out), 32'(m_out));
        check("out_valid", 32'(out_valid), 32'(m_vld));
        check("out_clk", 32'(out_clk), 32'(m_clk));
        check("active_ch", 32'(active_ch), 32'(m_act));
        check("passing", 32'(passing), 32'(m_mode == 2));
        check("err_multi", 32'(err_multi), 32'(m_err));
        check("sample_cnt", 32'(sample_cnt), 32'(m_cnt));
    endtask

    task automatic step(input logic [NCH-1:0] en, input logic [NCH-1:0] vmask,
                        input bit rnd, input bit fix1);
        enable   = en;
        in_valid = rnd ? (NCH'($urandom) & vmask) : vmask;
        for (int i = 0; i < NCH; i++) in_data[i*BW +: BW] = BW'($urandom);
        if (fix1) in_data[1*BW +: BW] = 21'h0ABCDE;
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        @(negedge clk);
        check_all();
    endtask

    logic [NCH-1:0] en_tab [8];
    int             pulses;

    initial begin
        en_tab = '{4'b0000, 4'b0001, 4'b0010, 4'b0100,
                   4'b1000, 4'b0011, 4'b0110, 4'b1111};
        model_reset();
        @(negedge clk);
        check_all();
        rst = 1'b0;

        // enable ch1, PASS after BLANK_CYC+2 edges
        for (int j = 0; j < 6; j++) step(4'b0010, 4'b0000, 0, 0);
        check("pass_early", 32'(passing), 32'd0);
        step(4'b0010, 4'b0000, 0, 0);
        check("pass_rise", 32'(passing), 32'd1);
        check("pass_ch", 32'(active_ch), 32'd1);
        step(4'b0010, 4'b0010, 0, 1);
        check("d1_out", 32'(out), 32'h0ABCDE);
        check("d1_vld", 32'(out_valid), 32'd1);
        check("d1_cnt", 32'(sample_cnt), 32'd1);
        step(4'b0010, 4'b0000, 0, 0);
        check("d1_oclk", 32'(out_clk), 32'd1);
        check("d1_hold", 32'(out), 32'h0ABCDE);

        // switch ch1 -> ch2 with back-to-back streaming
        for (int j = 0; j < 5; j++) step(4'b0010, 4'b0110, 0, 0);
        for (int j = 0; j < 14; j++) step(4'b0100, 4'b0110, 0, 0);

        // multi-enable
        for (int j = 0; j < 12; j++) step(4'b0011, 4'b0011, 0, 0);
        check("multi_err", 32'(err_multi), 32'd1);
        check("multi_idle", 32'(out_valid), 32'd0);

        // glitch inside BLANK
        for (int j = 0; j < 4; j++) step(4'b0000, 4'b1111, 1, 0);
        for (int j = 0; j < 3; j++) step(4'b0010, 4'b1111, 1, 0);
        for (int j = 0; j < 2; j++) step(4'b0100, 4'b1111, 1, 0);
        for (int j = 0; j < 16; j++) step(4'b0010, 4'b1111, 1, 0);

        // saturation: 20 samples on ch0
        for (int j = 0; j < 12; j++) step(4'b0001, 4'b0000, 0, 0);
        pulses = 0;
        for (int j = 0; j < 20; j++) begin
            step(4'b0001, 4'b0001, 0, 0);
            if (out_valid) pulses++;
        end
        check("sat_pulses", 32'(pulses), 32'd20);
        check("sat_cnt", 32'(sample_cnt), 32'd15);

        // async reset mid-PASS
        step(4'b0001, 4'b0001, 0, 0);
        rst = 1'b1;
        #1;
        check("rst_out", 32'(out), 32'd0);
        check("rst_pass", 32'(passing), 32'd0);
        check("rst_cnt", 32'(sample_cnt), 32'd0);
        check("rst_vld", 32'(out_valid), 32'd0);
        model_reset();
        step(4'b0001, 4'b0001, 0, 0);
        rst = 1'b0;
        for (int j = 0; j < 12; j++) step(4'b0001, 4'b0001, 1, 0);

        // random enable segments
        for (int s = 0; s < 40; s++) begin
            logic [NCH-1:0] en;
            int hold;
            en   = en_tab[$urandom_range(0, 7)];
            hold = $urandom_range(1, 14);
            for (int j = 0; j < hold; j++) step(en, 4'b1111, 1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/output_stream_selector.md
# output_stream_selector

Parametrised, registered test-output selector. It routes one of NCH sample streams (DFE output, ADC TEG words, future test sources) to the chip's shared digital output bus, together with a forwarded output strobe. Compared with the previous combinational selector, it adds:

- synchronised enables;
- a blanking interval on every source change, so the pad bus never shows a mixed or partial word;
- a per-sample output strobe;
- a multi-enable error flag;
- a saturating sample counter.

## Interface
- BW, 21: sample width of every source and of OUT (signed).
- NCH, 4: number of input channels (≥2).
- BLANK_CYC, 4: blanking cycles inserted on a source change (≥1).
- CNTW, 16: SAMPLE_CNT width.

- CLK  in  1  single clock; all logic is rising-edge.
- RST  in  1  asynchronous, active-high reset.
- IN_DATA  in  NCH*BW  flattened samples; channel i occupies [i*BW +: BW].
- IN_VALID  in  NCH  per-channel sample-valid strobe, 1 cycle per sample.
- ENABLE  in  NCH  one-hot channel enable, quasi-static, may be asynchronous to CLK.
- OUT  out  BW  selected sample, registered.
- OUT_VALID  out  1  high for the one cycle in which OUT takes a new sample.
- OUT_CLK  out  1  forwarded strobe, high the cycle after OUT_VALID.
- ACTIVE_CH  out  $clog2(NCH)  channel currently passed; meaningful only while PASSING.
- PASSING  out  1  high in state PASS.
- ERR_MULTI  out  1  more than one ENABLE bit set (synchronised view).
- SAMPLE_CNT  out  CNTW  samples forwarded since the last entry into PASS; saturates at all-ones.

## Operation
- ENABLE passes through a 2-flop synchroniser to give ENS.
- Decode of ENS:
  - exactly one bit set: target = that index, tgt_ok = 1;
  - zero bits or more than one bit set: tgt_ok = 0;
  - ERR_MULTI is registered as popcount(ENS) > 1.
- FSM states: IDLE, BLANK, PASS.
  - IDLE: OUT = 0, OUT_VALID = 0. If tgt_ok, latch the target into ACTIVE_CH and go to BLANK.
  - BLANK: OUT forced to 0, OUT_VALID = 0, and a down-counter runs for BLANK_CYC cycles. On expiry:
    - tgt_ok and target == ACTIVE_CH: go to PASS and clear SAMPLE_CNT;
    - tgt_ok and target ≠ ACTIVE_CH: latch the new target and restart BLANK;
    - !tgt_ok: go to IDLE.
  - PASS: on IN_VALID[ACTIVE_CH] = 1, register OUT ← IN_DATA slice, pulse OUT_VALID, and increment SAMPLE_CNT (saturating). IN_VALID of other channels is ignored.
    - If !tgt_ok: go to IDLE and set OUT to 0.
    - If target ≠ ACTIVE_CH: latch the target and go to BLANK; OUT is set to 0 in the same edge.
- If a sample is valid in the same cycle the target changes, the change wins and the sample is dropped.
- Between samples in PASS, OUT holds its last value.
- OUT_CLK is a 1-cycle-delayed copy of OUT_VALID, so OUT is stable for at least one full cycle before the OUT_CLK rising edge.
- No width conversion. Packing of narrower sources (e.g. {1'b0, TEG1, TEG2}) is done by the instantiating level.

## Timing
- Reset values:
  - OUT = 0, OUT_VALID = 0, OUT_CLK = 0;
  - ACTIVE_CH = 0, PASSING = 0, ERR_MULTI = 0, SAMPLE_CNT = 0;
  - state = IDLE, synchroniser = 0.
- Reset asserted mid-operation returns every output to these values immediately (asynchronously). There is no pending-state memory.
- Switching latency:
  - ENABLE change captured at edge k gives ENS at edge k+1.
  - The FSM reacts at edge k+2.
  - PASS is entered at edge k+2+BLANK_CYC.
  - The first forwardable sample is the IN_VALID sampled at that edge or later.
- Data latency in PASS: 1 cycle, IN_VALID/IN_DATA at edge n gives OUT/OUT_VALID after edge n, and OUT_CLK high after edge n+1.
- Back-to-back IN_VALID on consecutive cycles is supported. OUT_CLK is then continuously high, and the downstream samples on OUT_VALID.
- SAMPLE_CNT at all-ones stays all-ones; OUT_VALID still pulses.
- An enable glitch shorter than one synchronised cycle that resolves to the same target still restarts BLANK. This is intended.

## Structure
- Shared package (test_sel_pkg):
  - FSM state encoding (IDLE = 2'd0, BLANK = 2'd1, PASS = 2'd2);
  - a helper function for the one-hot/popcount decode.
- One sub-module, sync_2ff (width-parametrised 2-flop synchroniser with async active-high reset to 0), reused for ENABLE.
- Everything else, including the slice mux, FSM, counters and strobe, lives in output_stream_selector.

## Test plan
- Reset then ENABLE = 4'b0010 → PASSING rises BLANK_CYC+2 cycles after the ENABLE change with ACTIVE_CH = 1. IN_VALID[1] with IN_DATA ch1 = 21'h0ABCDE → OUT = 21'h0ABCDE, 1-cycle OUT_VALID, OUT_CLK one cycle later, SAMPLE_CNT = 1.
- In PASS on ch1, switch ENABLE to 4'b0100 while ch1 and ch2 stream back-to-back → OUT = 0 and OUT_VALID = 0 for the whole blank. No ch1 sample appears after the switch edge. First ch2 sample appears after the blank. SAMPLE_CNT restarts at 1.
- ENABLE = 4'b0011 → ERR_MULTI = 1, FSM in IDLE, OUT = 0, no OUT_VALID despite IN_VALID on ch0/ch1 (matches the old both-enabled = 0 behaviour).
- Toggle ENABLE 0010→0100→0010 within BLANK → BLANK restarts and ends on ch1, with no OUT_VALID during the sequence.
- With CNTW = 4, forward 20 samples → SAMPLE_CNT saturates at 15 and OUT_VALID pulses 20 times.
- Assert RST mid-PASS with OUT nonzero → all outputs 0 immediately. After release with ENABLE unchanged → full synchroniser + blank latency before the first sample.
